mblk_scan_reader: RTL
=====================

# mblk_scan_reader

Macroblock-order read address sequencer for the image-processing pipeline. The raster writer fills a frame buffer line by line. This block is its reader side: it walks that buffer one macroblock at a time (64x64, 32x32 or 16x16, per `teMacroBlockType`) and emits one pixel address per handshake to the memory read port. It sits between the frame-buffer controller and the block-based processing stages.

## Interface
Parameters:
- `ADDR_W`, 22, pixel address width
- `DIM_W`, 12, frame width/height counter width

Ports:
- `iClk`  in  1  clock
- `iRst`  in  1  reset, asynchronous, active-high
- `iStart`  in  1  one-cycle request to scan a frame; accepted only in IDLE
- `ieMbType`  in  2  `teMacroBlockType`, sampled on accepted `iStart`
- `iFrameWidth`  in  DIM_W  frame width in pixels, sampled on `iStart`
- `iFrameHeight`  in  DIM_W  frame height in pixels, sampled on `iStart`
- `iBaseAddr`  in  ADDR_W  pixel address of frame (0,0), sampled on `iStart`
- `oAddr`  out  ADDR_W  current pixel address
- `oAddrValid`  out  1  `oAddr` valid
- `iAddrReady`  in  1  consumer accepts `oAddr`
- `oMbFirst`  out  1  `oAddr` is pixel (0,0) of a macroblock
- `oMbLast`  out  1  `oAddr` is the last pixel of a macroblock
- `oFrameLast`  out  1  `oAddr` is the final address of the frame
- `oBusy`  out  1  scan in progress (not IDLE)
- `oDone`  out  1  one-cycle pulse after the last transfer
- `oErr`  out  1  configuration error; sticky until the next accepted `iStart`

## Operation
- Block size N = 64/32/16 for `MBLK64X64`/`MBLK32X32`/`MBLK16X16`; log2N = 6/5/4.
- Scan order: x within block fastest, then y within block, then block column, then block row.
- Address = base + (mbRow·N + y)·W + mbCol·N + x. Computed incrementally with a row-start pointer and adders; no multipliers. Arithmetic is modulo 2^ADDR_W.
- States:
  - IDLE: accept `iStart` -> CHECK.
  - CHECK: valid config -> SCAN; invalid config -> IDLE with `oErr`=1.
  - SCAN: advance on each transfer; after the transfer flagged `oFrameLast` -> DONE.
  - DONE: `oDone`=1 for one cycle -> IDLE.
- Transfer = `oAddrValid && iAddrReady`. While `oAddrValid`=1 and `iAddrReady`=0, `oAddr` and all flags hold stable.
- `oMbFirst`, `oMbLast` and `oFrameLast` are qualified by `oAddrValid`. For a single-pixel-per-block case both flags may be set; this cannot occur with N≥16.
- `iStart` outside IDLE is ignored; the scan is not restarted.
- Zero width or height is a config error.

## Timing
- Reset values: `oAddr`=0, `oAddrValid`=0, `oMbFirst`=0, `oMbLast`=0, `oFrameLast`=0, `oBusy`=0, `oDone`=0, `oErr`=0; state IDLE; all counters 0.
- `iStart` sampled at edge T: `oBusy`=1 from T. With the CHECK state, the first `oAddrValid` rises at T+1; without it, at T.
- Back-to-back transfers sustain one address per cycle; no bubbles at block or row boundaries.
- After the final transfer at edge F: `oAddrValid`=0 from F, `oDone`=1 during F..F+1, `oBusy`=0 from F+1. A new `iStart` is accepted from F+1.
- `iRst` asserted mid-scan: outputs return to reset values immediately (asynchronous). The pending address is dropped; there is no resume.

## Configuration
- `MBLK_SCAN_CFGCHK_EN` defined:
  - CHECK state present.
  - Error conditions: `ieMbType`=2'b00; width or height zero; width or height not a multiple of N.
  - Any error sets `oErr`.
- Not defined:
  - CHECK state removed; IDLE goes straight to SCAN.
  - `oErr` tied 0.
  - Behaviour with invalid configuration is undefined.

## Structure
- The shared image-processing package holds `teMacroBlockType` and gains:
  - the `MBLK_LOG2` mapping function (type -> log2N);
  - the `teMbScanState` enum (IDLE, CHECK, SCAN, DONE).
- One natural sub-module, `mblk_scan_counter`: nested x/y/col/row counters with wrap flags. The top level holds the FSM, address adders and handshake register.

## Test plan
- 16x16, W=32, H=16, base 0, ready=1:
  - sequence 0..15, 32..47, …, 480..495, then 16..31, 48..63, …, 496..511;
  - `oMbFirst` on 0 and 16; `oMbLast` on 495 and 511; `oFrameLast` on 511;
  - 512 transfers, then a single `oDone` pulse.
- Same frame, `iAddrReady` low for 3 cycles while `oAddr`=15: `oAddr` holds 15 with all flags stable; 32 follows on the first cycle after ready returns.
- 64x64, W=128, H=64, base 0x1000: first address 0x1000; 65th transfer 0x1000+128; 4097th transfer 0x1000+64 with `oMbFirst`=1.
- `MBLK_SCAN_CFGCHK_EN` defined:
  - `ieMbType`=2'b00 -> `oErr`=1, `oAddrValid` never rises, back to IDLE after 1 cycle;
  - 16x16 with W=40 -> `oErr`=1.
- `iStart` pulsed again mid-scan -> ignored; the sequence continues unchanged.
- `iRst` pulsed at transfer 100 -> all outputs 0 immediately; a fresh `iStart` restarts at the base address.

Source files
------------

// File: rtl/mblk_scan_reader_pkg.sv
// Shared image-processing types: macroblock type, block-size mapping and the
// macroblock scan reader state encoding.
package mblk_scan_reader_pkg;

    typedef enum logic [1:0] {
        MBLK_NONE = 2'b00,
        MBLK64X64 = 2'b01,
        MBLK32X32 = 2'b10,
        MBLK16X16 = 2'b11
    } teMacroBlockType;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } teMbScanState;

    // Width of the in-block x/y counters (largest block is 64 pixels).
    localparam int MBLK_XY_W = 6;

    function automatic logic [2:0] MBLK_LOG2(input teMacroBlockType eType);
        case (eType)
            MBLK64X64: return 3'd6;
            MBLK32X32: return 3'd5;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mblk_scan_reader_counter.sv
// Nested macroblock scan counters (x, y inside a block, then block column,
// then block row) with last-value wrap flags.
module mblk_scan_counter
    import mblk_scan_reader_pkg::*;
#(
    parameter int DIM_W = 12
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iClr,
    input  logic             iAdv,
    input  logic [2:0]       iLog2N,
    input  logic [DIM_W-1:0] iLastCol,
    input  logic [DIM_W-1:0] iLastRow,
    output logic             oMbFirst,
    output logic             oXWrap,
    output logic             oYWrap,
    output logic             oColWrap,
    output logic             oRowWrap
);

    logic [MBLK_XY_W-1:0] x_q, x_d, y_q, y_d, n_m1;
    logic [DIM_W-1:0]     col_q, col_d, row_q, row_d;
    logic                 x_wrap, y_wrap, col_wrap, row_wrap;

    // N-1; for N=64 the shift overflows to 0 and the subtraction yields 63.
    assign n_m1     = (MBLK_XY_W'(1) << iLog2N) - MBLK_XY_W'(1);
    assign x_wrap   = (x_q == n_m1);
    assign y_wrap   = (y_q == n_m1);
    assign col_wrap = (col_q == iLastCol);
    assign row_wrap = (row_q == iLastRow);

    assign oMbFirst = (x_q == '0) && (y_q == '0);
    assign oXWrap   = x_wrap;
    assign oYWrap   = y_wrap;
    assign oColWrap = col_wrap;
    assign oRowWrap = row_wrap;

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        col_d = col_q;
        row_d = row_q;
        if (iClr) begin
            x_d   = '0;
            y_d   = '0;
            col_d = '0;
            row_d = '0;
        end else if (iAdv) begin
            x_d = x_wrap ? '0 : x_q + MBLK_XY_W'(1);
            if (x_wrap) begin
                y_d = y_wrap ? '0 : y_q + MBLK_XY_W'(1);
                if (y_wrap) begin
                    col_d = col_wrap ? '0 : col_q + DIM_W'(1);
                    if (col_wrap) begin
                        row_d = row_wrap ? '0 : row_q + DIM_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            x_q   <= '0;
            y_q   <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/mblk_scan_reader.sv
// Macroblock-order frame-buffer read address sequencer.
// Optional configuration check state enabled by MBLK_SCAN_CFGCHK_EN.
module mblk_scan_reader
    import mblk_scan_reader_pkg::*;
#(
    parameter int ADDR_W = 22,
    parameter int DIM_W  = 12
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic [1:0]        ieMbType,
    input  logic [DIM_W-1:0]  iFrameWidth,
    input  logic [DIM_W-1:0]  iFrameHeight,
    input  logic [ADDR_W-1:0] iBaseAddr,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oAddrValid,
    input  logic              iAddrReady,
    output logic              oMbFirst,
    output logic              oMbLast,
    output logic              oFrameLast,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr
);

    // Handshake: oAddr and its flags are offered while oAddrValid is high and
    // are held unchanged until a cycle with iAddrReady high consumes them.

    teMbScanState    state_q, state_d;
    teMacroBlockType type_q, type_d;
    logic [DIM_W-1:0]  width_q, width_d, height_q, height_d;
    logic [ADDR_W-1:0] band_q, band_d, blk_q, blk_d, line_q, line_d, addr_q, addr_d;

    logic [2:0]        log2n;
    logic [ADDR_W-1:0] w_addr, n_addr, band_step, next_line, next_blk, next_band;
    logic [DIM_W-1:0]  last_col, last_row;
    logic              start_acc, xfer, scanning;
    logic              mb_first, x_wrap, y_wrap, col_wrap, row_wrap, frame_last;

    assign log2n     = MBLK_LOG2(type_q);
    assign w_addr    = ADDR_W'(width_q);
    assign n_addr    = ADDR_W'(1) << log2n;
    assign band_step = w_addr << log2n;
    assign last_col  = (width_q >> log2n) - DIM_W'(1);
    assign last_row  = (height_q >> log2n) - DIM_W'(1);

    // Pointers: band = first pixel of the block row, blk = block origin,
    // line = start of the current line inside the block.
    assign next_line = line_q + w_addr;
    assign next_blk  = blk_q + n_addr;
    assign next_band = band_q + band_step;

    assign scanning   = (state_q == SCAN);
    assign start_acc  = (state_q == IDLE) && iStart;
    assign xfer       = scanning && iAddrReady;
    assign frame_last = x_wrap && y_wrap && col_wrap && row_wrap;

    mblk_scan_counter #(.DIM_W(DIM_W)) u_cnt (
        .iClk     (iClk),
        .iRst     (iRst),
        .iClr     (start_acc),
        .iAdv     (xfer),
        .iLog2N   (log2n),
        .iLastCol (last_col),
        .iLastRow (last_row),
        .oMbFirst (mb_first),
        .oXWrap   (x_wrap),
        .oYWrap   (y_wrap),
        .oColWrap (col_wrap),
        .oRowWrap (row_wrap)
    );

`ifdef MBLK_SCAN_CFGCHK_EN
    logic             err_q, err_d, cfg_ok;
    logic [DIM_W-1:0] blk_mask;

    assign blk_mask = (DIM_W'(1) << log2n) - DIM_W'(1);
    assign cfg_ok   = (type_q != MBLK_NONE) && (width_q != '0) && (height_q != '0) &&
                      ((width_q & blk_mask) == '0) && ((height_q & blk_mask) == '0);
    assign oErr     = err_q;
`else
    assign oErr     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
`ifdef MBLK_SCAN_CFGCHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (iStart) begin
`ifdef MBLK_SCAN_CFGCHK_EN
                    state_d = CHECK;
                    err_d   = 1'b0;
`else
                    state_d = SCAN;
`endif
                end
            end
`ifdef MBLK_SCAN_CFGCHK_EN
            CHECK: begin
                state_d = cfg_ok ? SCAN : IDLE;
                err_d   = !cfg_ok;
            end
`endif
            SCAN:    if (xfer && frame_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        type_d   = type_q;
        width_d  = width_q;
        height_d = height_q;
        band_d   = band_q;
        blk_d    = blk_q;
        line_d   = line_q;
        addr_d   = addr_q;
        if (start_acc) begin
            type_d   = teMacroBlockType'(ieMbType);
            width_d  = iFrameWidth;
            height_d = iFrameHeight;
            band_d   = iBaseAddr;
            blk_d    = iBaseAddr;
            line_d   = iBaseAddr;
            addr_d   = iBaseAddr;
        end else if (xfer) begin
            if (!x_wrap) begin
                addr_d = addr_q + ADDR_W'(1);
            end else if (!y_wrap) begin
                line_d = next_line;
                addr_d = next_line;
            end else if (!col_wrap) begin
                blk_d  = next_blk;
                line_d = next_blk;
                addr_d = next_blk;
            end else begin
                band_d = next_band;
                blk_d  = next_band;
                line_d = next_band;
                addr_d = next_band;
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q  <= IDLE;
            type_q   <= MBLK_NONE;
            width_q  <= '0;
            height_q <= '0;
            band_q   <= '0;
            blk_q    <= '0;
            line_q   <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            width_q  <= width_d;
            height_q <= height_d;
            band_q   <= band_d;
            blk_q    <= blk_d;
            line_q   <= line_d;
            addr_q   <= addr_d;
        end
    end

`ifdef MBLK_SCAN_CFGCHK_EN
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) err_q <= 1'b0;
        else      err_q <= err_d;
    end
`endif

    assign oAddr      = addr_q;
    assign oAddrValid = scanning;
    assign oMbFirst   = scanning && mb_first;
    assign oMbLast    = scanning && x_wrap && y_wrap;
    assign oFrameLast = scanning && frame_last;
    assign oBusy      = (state_q != IDLE);
    assign oDone      = (state_q == DONE);

endmodule
